iob_pcie_chnl_dma: RTL
======================

Name: iob_pcie_chnl_dma

Overview:
- Full-duplex, parametrised RIFFA-style PCIe channel endpoint.
- Replaces the single-register, half-duplex loopback channel with independent RX and TX state machines, each buffered by its own FIFO.
- Sits between the PCIe core channel pins and a core-side streaming interface; the CPU register file or an accelerator drives that interface.
- Generalised in PCIe data width and buffer depth; supports back-to-back transfers and length-0 transactions.

Parameters:
- C_PCI_DATA_WIDTH, 64, PCIe channel data width; legal values 32, 64, 128.
- FIFO_DEPTH_LOG2, 4, log2 of the beat depth of each FIFO (RX and TX).
- LEN_W, 32, width of the channel length fields (units: 32-bit words).

Ports:
- clk  in  1  single clock for the PCIe channel and the core side; also driven out on chnl_rx_clk and chnl_tx_clk.
- arst_n  in  1  asynchronous, active-low reset.
- chnl_rx_clk  out  1  equals clk.
- chnl_rx  in  1  RX transaction request.
- chnl_rx_ack  out  1  RX accept.
- chnl_rx_last  in  1  ignored; recorded in rx_last_o.
- chnl_rx_len  in  LEN_W  RX length in 32-bit words.
- chnl_rx_off  in  LEN_W-1  ignored.
- chnl_rx_data  in  C_PCI_DATA_WIDTH  RX data beat.
- chnl_rx_data_valid  in  1  RX beat valid.
- chnl_rx_data_ren  out  1  RX beat accept.
- chnl_tx_clk  out  1  equals clk.
- chnl_tx  out  1  TX transaction request.
- chnl_tx_ack  in  1  TX accepted by the core.
- chnl_tx_last  out  1  constant 1.
- chnl_tx_len  out  LEN_W  TX length in 32-bit words.
- chnl_tx_off  out  LEN_W-1  constant 0.
- chnl_tx_data  out  C_PCI_DATA_WIDTH  TX data beat.
- chnl_tx_data_valid  out  1  TX beat valid.
- chnl_tx_data_ren  in  1  TX beat accept.
- rx_data_o  out  C_PCI_DATA_WIDTH  head of the RX FIFO (show-ahead).
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  pop RX FIFO.
- rx_len_o  out  LEN_W  length of the last accepted RX transaction.
- rx_last_o  out  1  chnl_rx_last sampled at accept.
- rx_done_o  out  1  one-cycle pulse at end of RX transaction.
- tx_data_i  in  C_PCI_DATA_WIDTH  TX FIFO write data.
- tx_valid_i  in  1  push TX FIFO.
- tx_ready_o  out  1  TX FIFO not full.
- tx_len_i  in  LEN_W  TX length, sampled on tx_start_i.
- tx_start_i  in  1  start a TX transaction.
- tx_busy_o  out  1  TX FSM not idle.
- tx_done_o  out  1  one-cycle pulse when the last TX beat is accepted.
- rx_level_o, tx_level_o  out  FIFO_DEPTH_LOG2+1  FIFO occupancy in beats.

Behaviour:
- WPB = C_PCI_DATA_WIDTH/32.
- beats(len) = ceil(len/WPB), computed as (len+WPB-1)>>log2(WPB) at LEN_W+1 bits; no overflow at len = all-ones.
- Reset (arst_n low, asynchronous):
  - Both FSMs go to IDLE and both FIFOs are flushed.
  - All outputs are 0 except chnl_tx_last=1 and tx_ready_o=1.
- RX FSM states: IDLE, ACK, DATA.
  - IDLE: when chnl_rx=1, latch len into rx_len_o, latch chnl_rx_last into rx_last_o, compute the beat target, clear the beat count, go to ACK.
  - ACK: chnl_rx_ack=1 for exactly one cycle. If the beat target is 0, pulse rx_done_o and go to IDLE; otherwise go to DATA.
  - DATA: chnl_rx_data_ren = RX FIFO not full.
    - A beat is pushed when valid&ren; beat count +1.
    - On the push that reaches the beat target, pulse rx_done_o next cycle and go to IDLE.
    - Beats with valid=0 are never pushed.
    - A full FIFO stalls via ren=0; no data is lost.
- TX FSM states: IDLE, REQ, DATA.
  - IDLE: on tx_start_i with tx_len_i≠0, latch the length and go to REQ.
    - tx_start_i with length 0 is ignored (no tx_done_o).
    - tx_start_i while not IDLE is ignored.
  - REQ: chnl_tx=1, chnl_tx_len=latched length; hold until chnl_tx_ack=1, then go to DATA.
  - DATA:
    - chnl_tx stays 1.
    - chnl_tx_data_valid = TX FIFO not empty; chnl_tx_data = TX FIFO head.
    - valid&ren pops one beat; count +1.
    - Popping the final beat: chnl_tx drops next cycle, tx_done_o pulses, FSM goes to IDLE.
    - An empty FIFO stalls with valid=0.
- The RX and TX FSMs are fully independent and operate concurrently in the same cycle.
- FIFOs:
  - Registered, synchronous.
  - Simultaneous push and pop on a full FIFO: push is blocked by ready/ren, pop proceeds.
  - Simultaneous push and pop on an empty FIFO: pop is blocked and the push lands.
  - Pointers wrap modulo the depth.
  - Pushing when full or popping when empty is impossible by construction.
  - tx_valid_i while full is dropped; tx_ready_o=0 signals this.
- Partial last beat:
  - TX: the upper words are don't-care; the host ignores them.
  - RX: the partial beat is stored whole.
- Pipeline latency:
  - RX: first data is visible on rx_valid_o 1 cycle after the push.
  - TX: first chnl_tx_data_valid appears in the cycle DATA is entered, if the FIFO is non-empty.

Test Plan:
- Reset: drive arst_n low mid-RX (DATA state, 3 of 8 beats pushed) -> RX and TX idle, rx_level_o=0, chnl_rx_ack=0, chnl_rx_data_ren=0, chnl_tx=0.
- RX, W=64: chnl_rx=1, len=7 -> ack for 1 cycle, 4 beats accepted (0x1..0x4), rx_done_o pulses once, rx_len_o=7, FIFO pops return 0x1..0x4 in order.
- RX backpressure, depth 16: len=40 words (20 beats), rx_ready_i=0 -> ren drops after 16 beats, rx_level_o=16; release -> remaining 4 beats accepted, rx_done_o pulses.
- TX: push 3 beats, tx_len_i=6, tx_start_i; ack delayed 5 cycles -> chnl_tx_len=6 held during REQ; with ren toggling 1,0,1,1 -> 3 beats emitted in order, tx_done_o pulses, chnl_tx falls.
- TX underflow and length 0: tx_start_i with len=0 -> no chnl_tx. tx_start_i with len=4 and empty FIFO -> valid=0 until pushes arrive, then 2 beats emitted.
- Full duplex: an RX of len=8 and a TX of len=8 run in the same cycles -> both complete, data intact, done pulses are independent.

Source files
------------

// File: rtl/iob_pcie_chnl_dma.sv
// Full-duplex RIFFA-style PCIe channel endpoint: independent RX and TX
// state machines, each buffered by its own show-ahead FIFO.

module iob_pcie_chnl_dma_fifo #(
  parameter int W  = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wrData,
  output logic [W-1:0]  rdData,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdData = mem[rdPtr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      level <= level + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end
endmodule

module iob_pcie_chnl_dma #(
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH_LOG2  = 4,
  parameter int LEN_W            = 32
) (
  input  logic                         clk,
  input  logic                         arst_n,
  output logic                         chnl_rx_clk,
  input  logic                         chnl_rx,
  output logic                         chnl_rx_ack,
  input  logic                         chnl_rx_last,
  input  logic [LEN_W-1:0]             chnl_rx_len,
  input  logic [LEN_W-2:0]             chnl_rx_off,
  input  logic [C_PCI_DATA_WIDTH-1:0]  chnl_rx_data,
  input  logic                         chnl_rx_data_valid,
  output logic                         chnl_rx_data_ren,
  output logic                         chnl_tx_clk,
  output logic                         chnl_tx,
  input  logic                         chnl_tx_ack,
  output logic                         chnl_tx_last,
  output logic [LEN_W-1:0]             chnl_tx_len,
  output logic [LEN_W-2:0]             chnl_tx_off,
  output logic [C_PCI_DATA_WIDTH-1:0]  chnl_tx_data,
  output logic                         chnl_tx_data_valid,
  input  logic                         chnl_tx_data_ren,
  output logic [C_PCI_DATA_WIDTH-1:0]  rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic [LEN_W-1:0]             rx_len_o,
  output logic                         rx_last_o,
  output logic                         rx_done_o,
  input  logic [C_PCI_DATA_WIDTH-1:0]  tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  input  logic [LEN_W-1:0]             tx_len_i,
  input  logic                         tx_start_i,
  output logic                         tx_busy_o,
  output logic                         tx_done_o,
  output logic [FIFO_DEPTH_LOG2:0]     rx_level_o,
  output logic [FIFO_DEPTH_LOG2:0]     tx_level_o
);
  localparam int WPB      = C_PCI_DATA_WIDTH / 32;
  localparam int WPB_LOG2 = $clog2(WPB);

  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_DATA} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_DATA} txState_t;

  // Beat count for a word length, one bit wider so all-ones cannot overflow.
  function automatic logic [LEN_W:0] beatsOf(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(WPB - 1);
    return sum >> WPB_LOG2;
  endfunction

  rxState_t rxState, rxNext;
  txState_t txState, txNext;

  logic [LEN_W:0]   rxTarget, rxCount, txTarget, txCount;
  logic [LEN_W-1:0] txLenQ;
  logic             rxPush, rxFull, rxEmpty, rxDoneNext;
  logic             txPop, txFull, txEmpty, txValid, txDoneNext;
  logic [C_PCI_DATA_WIDTH-1:0] rxHead, txHead;
  logic             unusedOff;

  assign unusedOff    = ^chnl_rx_off;
  assign chnl_rx_clk  = clk;
  assign chnl_tx_clk  = clk;
  assign chnl_tx_last = 1'b1;
  assign chnl_tx_off  = '0;
  assign chnl_tx_len  = txLenQ;
  assign chnl_tx_data_valid = txValid;
  assign chnl_tx_data = txValid ? txHead : '0;
  assign rx_valid_o   = ~rxEmpty;
  assign rx_data_o    = rxEmpty ? '0 : rxHead;
  assign tx_ready_o   = ~txFull;
  assign tx_busy_o    = (txState != TX_IDLE);

  iob_pcie_chnl_dma_fifo #(.W(C_PCI_DATA_WIDTH), .AW(FIFO_DEPTH_LOG2)) rxFifo (
    .clk(clk), .arst_n(arst_n), .push(rxPush), .pop(rx_ready_i),
    .wrData(chnl_rx_data), .rdData(rxHead), .full(rxFull), .empty(rxEmpty),
    .level(rx_level_o)
  );

  iob_pcie_chnl_dma_fifo #(.W(C_PCI_DATA_WIDTH), .AW(FIFO_DEPTH_LOG2)) txFifo (
    .clk(clk), .arst_n(arst_n), .push(tx_valid_i), .pop(txPop),
    .wrData(tx_data_i), .rdData(txHead), .full(txFull), .empty(txEmpty),
    .level(tx_level_o)
  );

  // State registers for both channel directions.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rxState <= RX_IDLE;
      txState <= TX_IDLE;
    end else begin
      rxState <= rxNext;
      txState <= txNext;
    end
  end

  // RX next-state and handshake outputs.
  always_comb begin
    rxNext           = rxState;
    chnl_rx_ack      = 1'b0;
    chnl_rx_data_ren = 1'b0;
    rxPush           = 1'b0;
    rxDoneNext       = 1'b0;
    case (rxState)
      RX_IDLE: if (chnl_rx) rxNext = RX_ACK;
      RX_ACK: begin
        chnl_rx_ack = 1'b1;
        if (rxTarget == '0) begin
          rxDoneNext = 1'b1;
          rxNext     = RX_IDLE;
        end else begin
          rxNext = RX_DATA;
        end
      end
      RX_DATA: begin
        chnl_rx_data_ren = ~rxFull;
        rxPush           = chnl_rx_data_valid & ~rxFull;
        if (rxPush && (rxCount + (LEN_W+1)'(1) == rxTarget)) begin
          rxDoneNext = 1'b1;
          rxNext     = RX_IDLE;
        end
      end
      default: rxNext = RX_IDLE;
    endcase
  end

  // TX next-state and handshake outputs.
  always_comb begin
    txNext     = txState;
    chnl_tx    = 1'b0;
    txValid    = 1'b0;
    txPop      = 1'b0;
    txDoneNext = 1'b0;
    case (txState)
      TX_IDLE: if (tx_start_i && (tx_len_i != '0)) txNext = TX_REQ;
      TX_REQ: begin
        chnl_tx = 1'b1;
        if (chnl_tx_ack) txNext = TX_DATA;
      end
      TX_DATA: begin
        chnl_tx = 1'b1;
        txValid = ~txEmpty;
        txPop   = txValid & chnl_tx_data_ren;
        if (txPop && (txCount + (LEN_W+1)'(1) == txTarget)) begin
          txDoneNext = 1'b1;
          txNext     = TX_IDLE;
        end
      end
      default: txNext = TX_IDLE;
    endcase
  end

  // Transaction bookkeeping: latched lengths, beat targets/counts, done pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_len_o  <= '0;
      rx_last_o <= 1'b0;
      rxTarget  <= '0;
      rxCount   <= '0;
      rx_done_o <= 1'b0;
      txLenQ    <= '0;
      txTarget  <= '0;
      txCount   <= '0;
      tx_done_o <= 1'b0;
    end else begin
      rx_done_o <= rxDoneNext;
      tx_done_o <= txDoneNext;
      if (rxState == RX_IDLE && chnl_rx) begin
        rx_len_o  <= chnl_rx_len;
        rx_last_o <= chnl_rx_last;
        rxTarget  <= beatsOf(chnl_rx_len);
        rxCount   <= '0;
      end else if (rxPush) begin
        rxCount <= rxCount + (LEN_W+1)'(1);
      end
      if (txState == TX_IDLE && tx_start_i && (tx_len_i != '0)) begin
        txLenQ   <= tx_len_i;
        txTarget <= beatsOf(tx_len_i);
        txCount  <= '0;
      end else if (txPop) begin
        txCount <= txCount + (LEN_W+1)'(1);
      end
    end
  end
endmodule
